// File: rtl/pr_freelist.sv
// Circular free list of physical register indices for rename: zero-latency
// allocation peek, in-order release at tail, and a committed head for squash.
module pr_freelist #(
   parameter int NUM_PR        = 64,
   parameter int NUM_ARCH      = 32,
   parameter int ALLOC_WIDTH   = 2,
   parameter int DEALLOC_WIDTH = 2,
   localparam int PRW   = $clog2(NUM_PR),
   localparam int DEPTH = NUM_PR - NUM_ARCH,
   localparam int IDXW  = $clog2(DEPTH),
   localparam int PTRW  = IDXW + 1,
   localparam int CCW   = $clog2(ALLOC_WIDTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ALLOC_WIDTH-1:0]         i_alloc_req,
   output logic                           o_can_alloc,
   output logic [ALLOC_WIDTH*PRW-1:0]     o_alloc_prIdx,
   input  logic [CCW-1:0]                 i_commit_cnt,
   input  logic                           i_squash,
   input  logic [DEALLOC_WIDTH-1:0]       i_dealloc_req,
   input  logic [DEALLOC_WIDTH*PRW-1:0]   i_dealloc_prIdx,
   output logic [PTRW-1:0]                o_free_count
);

   // Handshake: o_can_alloc acts as ready and i_alloc_req as valid; a grant
   // happens in a cycle only when both are set and no squash is present.
   // Release has no ready: every valid i_dealloc_req bit is accepted.
   logic [PTRW-1:0] head;
   logic [PTRW-1:0] commit_head;
   logic [PTRW-1:0] tail;
   logic [PRW-1:0]  storage [DEPTH];

   logic [PTRW-1:0] alloc_cnt;
   logic [PTRW-1:0] dealloc_cnt;
   logic [IDXW-1:0] wr_ptr [DEALLOC_WIDTH];
   logic            alloc_fire;

   always_comb begin
      alloc_cnt = '0;
      for (int k = 0; k < ALLOC_WIDTH; k++)
         alloc_cnt = alloc_cnt + PTRW'(i_alloc_req[k]);
   end

   // Each release port writes at tail plus the number of lower-numbered valid ports.
   always_comb begin
      dealloc_cnt = '0;
      for (int n = 0; n < DEALLOC_WIDTH; n++) begin
         wr_ptr[n]   = IDXW'(tail + dealloc_cnt);
         dealloc_cnt = dealloc_cnt + PTRW'(i_dealloc_req[n]);
      end
   end

   assign o_free_count = tail - head;
   assign o_can_alloc  = o_free_count >= PTRW'(ALLOC_WIDTH);
   assign alloc_fire   = o_can_alloc && !i_squash && (|i_alloc_req);

   always_comb begin
      o_alloc_prIdx = '0;
      for (int k = 0; k < ALLOC_WIDTH; k++)
         o_alloc_prIdx[k*PRW +: PRW] = storage[IDXW'(head + PTRW'(k))];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head        <= '0;
         commit_head <= '0;
         tail        <= PTRW'(DEPTH);
         for (int i = 0; i < DEPTH; i++)
            storage[i] <= PRW'(NUM_ARCH + i);
      end else begin
         commit_head <= commit_head + PTRW'(i_commit_cnt);
         // Squash rewinds to the committed point, counting this cycle's commits.
         if (i_squash)
            head <= commit_head + PTRW'(i_commit_cnt);
         else if (alloc_fire)
            head <= head + alloc_cnt;
         tail <= tail + dealloc_cnt;
         for (int n = 0; n < DEALLOC_WIDTH; n++)
            if (i_dealloc_req[n])
               storage[wr_ptr[n]] <= i_dealloc_prIdx[n*PRW +: PRW];
      end
   end

`ifndef SYNTHESIS
   logic [PTRW:0] push_level;
   assign push_level = {1'b0, o_free_count} + {1'b0, dealloc_cnt}
                     - {1'b0, (alloc_fire ? alloc_cnt : PTRW'(0))};

   a_alloc_contiguous: assert property (@(posedge clk) disable iff (rst)
      ((i_alloc_req & (i_alloc_req + ALLOC_WIDTH'(1))) == '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (push_level <= (PTRW+1)'(DEPTH)));
   a_commit_bound: assert property (@(posedge clk) disable iff (rst)
      (PTRW'(i_commit_cnt) <= PTRW'(head - commit_head)));
`endif

endmodule

// File: doc/pr_freelist.md
Name: pr_freelist

Overview:
- Circular free list of physical register indices for the rename stage.
- Hands out free PRs to rename, one per requesting slot.
- Takes back PRs released by the refcount block (its real-dealloc outputs) at commit.
- Keeps a committed-head pointer so that a pipeline squash restores all speculatively allocated PRs in one cycle.

Parameters:
- NUM_PR, 64, total physical registers; prIdx width PRW = clog2(NUM_PR).
- NUM_ARCH, 32, architectural registers; PR 0..NUM_ARCH-1 are mapped at reset and never start in the list.
- ALLOC_WIDTH, 2, rename allocation ports per cycle.
- DEALLOC_WIDTH, 2, release ports per cycle (matches refcount real-dealloc width).
- DEPTH, NUM_PR-NUM_ARCH, list capacity; must be a power of two; pointers are clog2(DEPTH)+1 bits (MSB is the wrap bit).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_alloc_req  in  ALLOC_WIDTH  per-slot allocation request; set bits must be contiguous from bit 0.
- o_can_alloc  out  1  free count >= ALLOC_WIDTH.
- o_alloc_prIdx  out  ALLOC_WIDTH*PRW  slot k = entry at head+k (combinational peek).
- i_commit_cnt  in  clog2(ALLOC_WIDTH+1)  number of allocations retired this cycle.
- i_squash  in  1  flush speculative allocations.
- i_dealloc_req  in  DEALLOC_WIDTH  release valid per port (from refcount o_real_dealloc_req).
- i_dealloc_prIdx  in  DEALLOC_WIDTH*PRW  released PR indices.
- o_free_count  out  clog2(DEPTH)+1  tail - head.

Behaviour:
- Reset (async, asserted immediately):
  - head = 0, commit_head = 0, tail = DEPTH (wrap bit set, list full).
  - storage[i] = NUM_ARCH+i.
  - Outputs after reset: o_free_count = DEPTH, o_can_alloc = 1, o_alloc_prIdx slot k = NUM_ARCH+k.
- Allocation is all-or-nothing:
  - Fires only when o_can_alloc=1, i_squash=0 and i_alloc_req != 0.
  - head advances by popcount(i_alloc_req).
  - Granted indices are the o_alloc_prIdx values shown in that cycle (zero-latency peek).
  - i_alloc_req with o_can_alloc=0 is ignored; the list does not change.
  - Non-contiguous request bits are illegal; simulation assertion.
- Release:
  - Each set i_dealloc_req bit, in port order 0..DEALLOC_WIDTH-1, writes its index at tail+n, where n counts lower set bits.
  - tail advances by popcount(i_dealloc_req).
  - Released entries are visible to allocation the next cycle.
  - Release is never blocked and is unaffected by squash.
  - A push that would make tail-head > DEPTH is illegal; simulation assertion.
- Commit:
  - commit_head advances by i_commit_cnt every cycle, including squash cycles.
  - i_commit_cnt must not exceed head-commit_head; simulation assertion.
- Squash: head <= commit_head + i_commit_cnt; allocation in the same cycle is suppressed.
- Same-cycle interactions:
  - Alloc + release: free count next cycle = old - alloc_cnt + dealloc_cnt.
  - o_can_alloc uses only the current count, never same-cycle releases.
- Wrap: pointers wrap modulo 2*DEPTH; storage is indexed by the low bits.
  - Empty: head == tail.
  - Full: low bits equal and wrap bits differ.
- Empty/near-empty: o_free_count < ALLOC_WIDTH drives o_can_alloc=0, even if only one slot is requesting.
- Reset mid-operation: all state returns to the reset values; in-flight requests are discarded.
- No internal FSM beyond the pointers; all state updates on posedge clk.

Test Plan:
- Reset, then alloc_req=2'b11 each cycle:
  - Cycle 0 grants 32,33; next cycle grants 34,35.
  - After 16 cycles o_free_count=0 and o_can_alloc=0.
- Drain list to 1 entry, alloc_req=2'b01 -> o_can_alloc=0, no grant, head unchanged. Then release PR 5 -> next cycle count=2, can_alloc=1, grant order oldest-first with 5 last.
- Alloc 4 PRs (32..35), commit_cnt=1, then squash -> head = commit_head = 1; next grant is 33.
- Squash + alloc_req=2'b11 + commit_cnt=2 in one cycle -> no grant; head = commit_head = 2.
- dealloc_req=2'b10 with prIdx {7,9} -> only 7 written at tail, tail+1. Same cycle alloc 2 -> count = old-2+1.
- Cycle 2*DEPTH allocations and releases -> wrap bits toggle correctly, full/empty flags correct, no lost or duplicated index. Scoreboard checks the set of live PRs ∪ free list = 0..63.
